seg7_scan_driver: RTL

//  Time-multiplexed driver for NUM_DIGITS common-anode/cathode 7-segment digits.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_decoder.sv | 16 +
 rtl/seg7_scan_driver.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment patterns in {a,b,c,d,e,f,g} order.
package seg7_pkg;

  // Entry n holds the pattern for nibble n; listed from 15 down to 0.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble to active-high {a..g} decoder; non-decimal nibbles show a dash
// unless hex display is enabled.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_en_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_LUT[nibble_i];
    if (!hex_en_i && (nibble_i > 4'd9)) seg_o = SEG_DASH;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: slot/digit scan counters, double-buffered display
// word for tear-free updates, leading-zero blanking and output polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYC    = 50000,
  parameter int BLANK_CYC   = 2,
  parameter int HEX_MODE    = 1,
  parameter int LZ_BLANK    = 1,
  parameter int SEG_ACT_LOW = 0,
  parameter int AN_ACT_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(SLOT_CYC);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic                  HEX_EN    = (HEX_MODE != 0);
  localparam logic                  LZ_EN     = (LZ_BLANK != 0);
  localparam logic [6:0]            SEG_OFF   = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF    = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = (AN_ACT_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  run_q, run_d;
  logic [VAL_W-1:0]      pend_q, pend_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic [NUM_DIGITS-1:0] nz_above;
  logic [3:0]            nib_sel;
  logic                  dp_sel;
  logic                  blank_sel;
  logic [6:0]            seg_dec;
  logic [6:0]            seg_raw;
  logic [NUM_DIGITS-1:0] an_raw;

  // The first enabled cycle after reset or a disabled stretch holds slot 0 of digit 0.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    run_d = enable;
    if (!enable || !run_q) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Shadow only changes at a frame boundary or while dark, so no frame mixes two words.
  always_comb begin
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    shadow_d     = shadow_q;
    shadow_dp_d  = shadow_dp_q;
    if (!enable || frame_done_q) begin
      if (load) begin
        shadow_d     = value;
        shadow_dp_d  = dp_in;
        pend_d       = value;
        pend_dp_d    = dp_in;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        shadow_d     = pend_q;
        shadow_dp_d  = pend_dp_q;
        pend_valid_d = 1'b0;
      end
    end else if (load) begin
      pend_d       = value;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
  end

  // Outputs are computed from next-state values so the registered pins line up with
  // the counter, index and shadow contents of the same cycle.
  always_comb begin
    logic acc;
    nz_above = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      acc = 1'b0;
      for (int j = i; j < NUM_DIGITS; j++) acc = acc | (|shadow_d[4*j +: 4]);
      nz_above[i] = acc;
    end
  end

  always_comb begin
    nib_sel   = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    an_raw    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib_sel   = shadow_d[4*i +: 4];
        dp_sel    = shadow_dp_d[i];
        blank_sel = LZ_EN && (i != 0) && !nz_above[i];
        an_raw[i] = enable && (cnt_d >= CNT_BLANK);
      end
    end
  end

  seg7_decoder u_decoder (
    .nibble_i (nib_sel),
    .hex_en_i (HEX_EN),
    .seg_o    (seg_dec)
  );

  always_comb begin
    seg_raw      = (enable && !blank_sel) ? seg_dec : SEG_BLANK;
    seg_d        = seg_raw ^ SEG_OFF;
    dp_d         = (enable && dp_sel) ^ DP_OFF;
    an_d         = an_raw ^ AN_OFF;
    frame_done_d = enable && (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      run_q        <= 1'b0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      run_q        <= run_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
